// File: rtl/object_pixel_resolver_if.sv
// Pixel request / resolved-pixel result bundle for object_pixel_resolver.
// master issues pixels and consumes results; slave is the resolver.
interface object_pixel_resolver_if;
  logic        pixel_valid;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        out_valid;
  logic        hit;
  logic [1:0]  obj_idx;
  logic [10:0] img_id;
  logic [10:0] x_offset;
  logic [10:0] y_offset;

  modport master (
    output pixel_valid, pixel_x, pixel_y,
    input  out_valid, hit, obj_idx, img_id, x_offset, y_offset
  );

  modport slave (
    input  pixel_valid, pixel_x, pixel_y,
    output out_valid, hit, obj_idx, img_id, x_offset, y_offset
  );
endinterface

// File: rtl/object_pixel_resolver.sv
// Resolves each pixel against a snapshotted object table: 3-stage pipeline
// (differences, in-range flags, priority select), one pixel per cycle.
module object_pixel_resolver #(
  parameter int unsigned NUM_OBJ = 3,
  parameter logic [10:0] MISS_ID = 11'h7FF
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           frame_start,
  input  logic [0:NUM_OBJ*5-1][0:10]     obj_table,
  output logic                           table_ready,
  object_pixel_resolver_if.slave         bus
);

  localparam int unsigned CW = 11;
  localparam int unsigned DW = 12;
  localparam int unsigned IW = 2;

  logic [0:NUM_OBJ*5-1][0:10] shadow;

  // stage 1: differences plus the entry fields needed downstream
  logic          s1_valid;
  logic          s1_ready;
  logic [DW-1:0] s1_dx [NUM_OBJ];
  logic [DW-1:0] s1_dy [NUM_OBJ];
  logic [CW-1:0] s1_w  [NUM_OBJ];
  logic [CW-1:0] s1_h  [NUM_OBJ];
  logic [CW-1:0] s1_id [NUM_OBJ];

  // stage 2: per-entry coverage flags
  logic          s2_valid;
  logic          s2_in [NUM_OBJ];
  logic [CW-1:0] s2_dx [NUM_OBJ];
  logic [CW-1:0] s2_dy [NUM_OBJ];
  logic [CW-1:0] s2_id [NUM_OBJ];

  logic          sel_hit;
  logic [IW-1:0] sel_idx;
  logic [CW-1:0] sel_id;
  logic [CW-1:0] sel_xo;
  logic [CW-1:0] sel_yo;

  // lowest covering index wins: scan high to low so lower entries overwrite
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = IW'(3);
    sel_id  = MISS_ID;
    sel_xo  = '0;
    sel_yo  = '0;
    for (int k = int'(NUM_OBJ) - 1; k >= 0; k--) begin
      if (s2_in[k]) begin
        sel_hit = 1'b1;
        sel_idx = IW'(k);
        sel_id  = s2_id[k];
        sel_xo  = s2_dx[k];
        sel_yo  = s2_dy[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      shadow       <= '0;
      table_ready  <= 1'b0;
      s1_valid     <= 1'b0;
      s1_ready     <= 1'b0;
      s2_valid     <= 1'b0;
      for (int k = 0; k < int'(NUM_OBJ); k++) begin
        s1_dx[k] <= '0;
        s1_dy[k] <= '0;
        s1_w[k]  <= '0;
        s1_h[k]  <= '0;
        s1_id[k] <= '0;
        s2_in[k] <= 1'b0;
        s2_dx[k] <= '0;
        s2_dy[k] <= '0;
        s2_id[k] <= '0;
      end
      bus.out_valid <= 1'b0;
      bus.hit       <= 1'b0;
      bus.obj_idx   <= '0;
      bus.img_id    <= '0;
      bus.x_offset  <= '0;
      bus.y_offset  <= '0;
    end else begin
      if (frame_start) begin
        shadow      <= obj_table;
        table_ready <= 1'b1;
      end

      // stage 1 samples the pre-update shadow in a frame_start cycle
      s1_valid <= bus.pixel_valid;
      if (bus.pixel_valid) begin
        s1_ready <= table_ready;
        for (int k = 0; k < int'(NUM_OBJ); k++) begin
          s1_dx[k] <= DW'({1'b0, bus.pixel_x}) - DW'({1'b0, shadow[5*k+1]});
          s1_dy[k] <= DW'({1'b0, bus.pixel_y}) - DW'({1'b0, shadow[5*k+2]});
          s1_w[k]  <= shadow[5*k+3];
          s1_h[k]  <= shadow[5*k+4];
          s1_id[k] <= shadow[5*k];
        end
      end

      // a borrow makes dx >= 2048 > any width, which also covers pixel < origin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        for (int k = 0; k < int'(NUM_OBJ); k++) begin
          s2_in[k] <= s1_ready && (s1_dx[k] < DW'({1'b0, s1_w[k]}))
                               && (s1_dy[k] < DW'({1'b0, s1_h[k]}));
          s2_dx[k] <= s1_dx[k][CW-1:0];
          s2_dy[k] <= s1_dy[k][CW-1:0];
          s2_id[k] <= s1_id[k];
        end
      end

      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.hit      <= sel_hit;
        bus.obj_idx  <= sel_idx;
        bus.img_id   <= sel_id;
        bus.x_offset <= sel_xo;
        bus.y_offset <= sel_yo;
      end
    end
  end

endmodule

// File: tb/tb_object_pixel_resolver.sv
// Scoreboard bench for object_pixel_resolver: directed pixels push expected
// results; a negedge monitor pops and compares every out_valid.
module tb_object_pixel_resolver;

  localparam int unsigned NUM_OBJ = 3;

  typedef struct {
    logic        hit;
    logic [1:0]  idx;
    logic [10:0] id;
    logic [10:0] xo;
    logic [10:0] yo;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic resetN;
  logic frame_start;
  logic table_ready;
  logic [0:NUM_OBJ*5-1][0:10] tbl;

  object_pixel_resolver_if bus();

  object_pixel_resolver #(.NUM_OBJ(NUM_OBJ), .MISS_ID(11'h7FF)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .frame_start (frame_start),
    .obj_table   (tbl),
    .table_ready (table_ready),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t last;
  bit   have_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_entry(input int k, input logic [10:0] id, input logic [10:0] x,
                           input logic [10:0] y, input logic [10:0] w, input logic [10:0] h);
    tbl[5*k]   = id;
    tbl[5*k+1] = x;
    tbl[5*k+2] = y;
    tbl[5*k+3] = w;
    tbl[5*k+4] = h;
  endtask

  // one pixel in the next cycle; expected result due three cycles later
  task automatic send(input logic [10:0] x, input logic [10:0] y, input logic fs,
                      input logic h, input logic [1:0] idx, input logic [10:0] id,
                      input logic [10:0] xo, input logic [10:0] yo);
    exp_t e;
    @(posedge clk); #1;
    bus.pixel_valid = 1'b1;
    bus.pixel_x     = x;
    bus.pixel_y     = y;
    frame_start     = fs;
    e.hit = h; e.idx = idx; e.id = id; e.xo = xo; e.yo = yo; e.due = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic send_miss(input logic [10:0] x, input logic [10:0] y);
    send(x, y, 1'b0, 1'b0, 2'd3, 11'h7FF, 11'd0, 11'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.pixel_valid = 1'b0;
      frame_start     = 1'b0;
    end
  endtask

  task automatic pulse_fs();
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0;
    frame_start     = 1'b1;
    idle(1);
  endtask

  // monitor: checks every result against the scoreboard and holds between results
  always @(negedge clk) begin
    if (resetN) begin
      have_last = 0;
    end else if (bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency",  32'(cyc), 32'(e.due));
        chk("hit",      32'(bus.hit), 32'(e.hit));
        chk("obj_idx",  32'(bus.obj_idx), 32'(e.idx));
        chk("img_id",   32'(bus.img_id), 32'(e.id));
        chk("x_offset", 32'(bus.x_offset), 32'(e.xo));
        chk("y_offset", 32'(bus.y_offset), 32'(e.yo));
        last = e;
        have_last = 1;
      end
    end else if (have_last) begin
      chk("hold_img_id",   32'(bus.img_id), 32'(last.id));
      chk("hold_x_offset", 32'(bus.x_offset), 32'(last.xo));
      chk("hold_obj_idx",  32'(bus.obj_idx), 32'(last.idx));
    end
  end

  initial begin
    resetN          = 1'b1;
    frame_start     = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_x     = '0;
    bus.pixel_y     = '0;
    set_entry(0, 11'd0,  11'd300, 11'd7,   11'd16,  11'd32);
    set_entry(1, 11'd0,  11'd256, 11'd380, 11'd16,  11'd32);
    set_entry(2, 11'd31, 11'd106, 11'd7,   11'd318, 11'd32);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_table_ready", 32'(table_ready), 32'd0);
    chk("rst_out_valid",   32'(bus.out_valid), 32'd0);
    chk("rst_hit",         32'(bus.hit), 32'd0);
    chk("rst_obj_idx",     32'(bus.obj_idx), 32'd0);
    chk("rst_img_id",      32'(bus.img_id), 32'd0);
    chk("rst_offsets",     32'({bus.x_offset, bus.y_offset}), 32'd0);
    @(posedge clk); #1;
    resetN = 1'b0;

    // no snapshot yet: everything misses
    send_miss(11'd300, 11'd7);
    idle(5);

    pulse_fs();
    @(negedge clk);
    chk("table_ready_set", 32'(table_ready), 32'd1);

    send(11'd305, 11'd10, 1'b0, 1'b1, 2'd0, 11'd0,  11'd5,   11'd3);
    send(11'd315, 11'd7,  1'b0, 1'b1, 2'd0, 11'd0,  11'd15,  11'd0);
    send(11'd316, 11'd7,  1'b0, 1'b1, 2'd2, 11'd31, 11'd210, 11'd0);
    send(11'd423, 11'd38, 1'b0, 1'b1, 2'd2, 11'd31, 11'd317, 11'd31);
    send_miss(11'd424, 11'd38);
    send_miss(11'd105, 11'd7);
    idle(5);

    // table edits only take effect on frame_start, and only for later pixels
    tbl[1] = 11'd0;
    send(11'd305, 11'd10, 1'b0, 1'b1, 2'd0, 11'd0,  11'd5,   11'd3);
    send(11'd305, 11'd10, 1'b1, 1'b1, 2'd0, 11'd0,  11'd5,   11'd3);
    send(11'd305, 11'd10, 1'b0, 1'b1, 2'd2, 11'd31, 11'd199, 11'd3);
    idle(5);
    chk("table_ready_stays", 32'(table_ready), 32'd1);

    tbl[1] = 11'd300;
    pulse_fs();
    for (int i = 0; i <= 10; i++)
      send(11'(300 + i), 11'd7, 1'b0, 1'b1, 2'd0, 11'd0, 11'(i), 11'd0);
    idle(6);

    // reset with two pixels in flight; reset also beats pixel_valid and frame_start
    send_miss(11'd300, 11'd7);
    send_miss(11'd301, 11'd7);
    @(posedge clk); #1;
    sb.delete();
    resetN          = 1'b1;
    bus.pixel_valid = 1'b1;
    frame_start     = 1'b1;
    @(posedge clk); #1;
    resetN          = 1'b0;
    bus.pixel_valid = 1'b0;
    frame_start     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    end
    chk("flush_table_ready", 32'(table_ready), 32'd0);

    // right-edge entry: no wrap of x+width; zero-size entries never hit
    set_entry(0, 11'd9, 11'd0,    11'd0, 11'd0,  11'd5);
    set_entry(1, 11'd5, 11'd2040, 11'd0, 11'd16, 11'd4);
    set_entry(2, 11'd1, 11'd0,    11'd0, 11'd10, 11'd0);
    pulse_fs();
    send(11'd2047, 11'd0, 1'b0, 1'b1, 2'd1, 11'd5, 11'd7, 11'd0);
    send_miss(11'd0, 11'd0);
    send(11'd2040, 11'd3, 1'b0, 1'b1, 2'd1, 11'd5, 11'd0, 11'd3);
    send_miss(11'd2040, 11'd4);
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/object_pixel_resolver.md
OBJECT_PIXEL_RESOLVER -- requirements
Module: object_pixel_resolver

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 3; number of 5-word object entries in the table.
REQ-002 SHALL have parameter MISS_ID, default 11'h7FF; img_id driven when no object covers the pixel.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-004 SHALL have port resetN  in  1  reset, synchronous, active-high (resetN=1 resets).
REQ-005 SHALL have port frame_start  in  1  one-cycle pulse that snapshots obj_table.
REQ-006 SHALL have port obj_table  in  [0:3*5-1][0:10]  object table; entry k is words 5k..5k+4 = img_id, x, y, width, height.
REQ-007 SHALL have port pixel_valid  in  1  pixel request strobe, accepted every cycle it is high.
REQ-008 SHALL have port pixel_x  in  11  requested pixel column.
REQ-009 SHALL have port pixel_y  in  11  requested pixel row.
REQ-010 SHALL have port table_ready  out  1  high once a snapshot has been taken since reset.
REQ-011 SHALL have port out_valid  out  1  result strobe.
REQ-012 SHALL have port hit  out  1  pixel covered by some object.
REQ-013 SHALL have port obj_idx  out  2  winning entry index; 3 on miss.
REQ-014 SHALL have port img_id  out  11  winning entry img_id; MISS_ID on miss.
REQ-015 SHALL have port x_offset  out  11  pixel_x minus winning entry x; 0 on miss.
REQ-016 SHALL have port y_offset  out  11  pixel_y minus winning entry y; 0 on miss.

Function
REQ-017 SHALL copy obj_table into an internal shadow table at the clock edge ending a cycle with frame_start=1, and set table_ready=1 there.
REQ-018 SHALL resolve every pixel against the shadow only; obj_table changes without frame_start SHALL have no effect.
REQ-019 SHALL resolve a pixel presented in the frame_start cycle against the pre-update shadow; pixels from the following cycle on SHALL use the new shadow.
REQ-020 SHALL be a 3-stage pipeline: S1 registers pixel, per-entry 12-bit differences dx=pixel_x-x, dy=pixel_y-y, and img_id; S2 registers per-entry in-range flags; S3 registers the priority-selected outputs.
REQ-021 SHALL drive out_valid=1 exactly 3 cycles after each pixel_valid=1 cycle, with throughput of 1 pixel/cycle and no stalls.
REQ-022 SHALL treat entry k as covering the pixel iff pixel_x>=x AND dx<width AND pixel_y>=y AND dy<height, using unsigned compares at 12 bits so x+width>2047 never wraps.
REQ-023 SHALL never hit an entry with width=0 or height=0.
REQ-024 SHALL select the lowest covering index when entries overlap (entry 0 over 1 over 2).
REQ-025 SHALL hold hit, obj_idx, img_id, x_offset and y_offset at their last values when out_valid=0.
REQ-026 SHALL report a miss for every pixel while table_ready=0.
REQ-027 SHALL take no further action on a repeated frame_start other than re-snapshotting; table_ready SHALL stay 1.

Reset
REQ-028 SHALL, in any cycle with resetN=1, clear shadow to all-zero, table_ready=0, out_valid=0, hit=0, obj_idx=0, img_id=0, x_offset=0 and y_offset=0, and clear all stage valids.
REQ-029 SHALL discard in-flight pixels on reset mid-operation, so no out_valid is produced for them.
REQ-030 SHALL take reset priority over a simultaneous frame_start or pixel_valid.

Verification
REQ-031 SHALL pass this scenario: after reset with no frame_start, pixel (300,7) -> 3 cycles later out_valid=1, hit=0, obj_idx=3, img_id=0x7FF, offsets 0.
REQ-032 SHALL pass this scenario: table e0={0,300,7,16,32}, e1={0,256,380,16,32}, e2={31,106,7,318,32}, then frame_start, then pixel (305,10) -> hit=1, obj_idx=0, img_id=0, x_offset=5, y_offset=3 (e2 overlap loses to e0).
REQ-033 SHALL pass these boundary scenarios on that table: (315,7) -> obj_idx 0, x_offset 15; (316,7) -> obj_idx 2, img_id 31, x_offset 210; (423,38) -> obj_idx 2, x_offset 317, y_offset 31; (424,38) -> miss; (105,7) -> miss.
REQ-034 SHALL pass this snapshot scenario: change e0.x to 0 without frame_start, then pixel (305,10) -> still obj_idx 0. Then pixel (305,10) in the frame_start cycle -> obj_idx 0. Then pixel (305,10) on the next cycle -> obj_idx 2, x_offset 199.
REQ-035 SHALL pass this streaming scenario: pixels (300..310,7) on 11 consecutive cycles -> 11 consecutive out_valid cycles, x_offset 0..10. Then resetN=1 with 2 pixels in flight -> out_valid=0 from the next cycle on.
REQ-036 SHALL pass this edge scenario: entry e1={5,2040,0,16,4}, then frame_start, then pixel (2047,0) -> obj_idx 1, x_offset 7. Pixel (0,0) -> miss, with no wrap of x+width.
